// File: rtl/apb_slave_regs.sv
// apb_slave_regs
// APB completer terminating one port of the APB demux. It holds a bank of
// SLAVE_REG_N read/write registers, one per address unit, starting at
// BASE_OFFSET. Every access phase is stretched by WAIT_STATES cycles.
// Out-of-window accesses complete with PSLVERR and have no side effects.
//
// Ports:
//   pclk_i      clock, all logic on the rising edge
//   prst_i      synchronous active-high reset
//   psel_i      select from the demux
//   penable_i   APB access-phase enable
//   pwrite_i    1 = write, 0 = read
//   paddr_i     byte/word address (one register per address unit)
//   pwdata_i    write data
//   pstrb_i     byte write strobes
//   prdata_o    read data, registered at setup, 0 outside the access phase
//   pready_o    transfer completes when high in the access phase
//   pslverr_o   error response, only ever high together with pready_o
//   regs_o      flattened register contents, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse_o  one-cycle strobe per register after a committed write
module apb_slave_regs #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SLAVE_REG_N = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_OFFSET = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                              pclk_i,
    input  logic                              prst_i,
    input  logic                              psel_i,
    input  logic                              penable_i,
    input  logic                              pwrite_i,
    input  logic [ADDR_WIDTH-1:0]             paddr_i,
    input  logic [DATA_WIDTH-1:0]             pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]           pstrb_i,
    output logic [DATA_WIDTH-1:0]             prdata_o,
    output logic                              pready_o,
    output logic                              pslverr_o,
    output logic [SLAVE_REG_N*DATA_WIDTH-1:0] regs_o,
    output logic [SLAVE_REG_N-1:0]            wr_pulse_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (SLAVE_REG_N > 1) ? $clog2(SLAVE_REG_N) : 1;

    // Window bounds carry one extra bit so BASE_OFFSET + SLAVE_REG_N can
    // reach the top of the address space without wrapping to zero.
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_OFFSET};
    localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, BASE_OFFSET} + (ADDR_WIDTH + 1)'(SLAVE_REG_N);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              cnt;
    logic [IDX_W-1:0]        idx_q;
    logic                    hit_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       strb_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic [SLAVE_REG_N-1:0]  wr_pulse_q;
    logic [DATA_WIDTH-1:0]   regs [SLAVE_REG_N];

    logic [ADDR_WIDTH:0]     addr_ext;
    logic                    hit_c;
    logic [IDX_W-1:0]        idx_c;
    logic                    setup;
    logic                    ready_int;
    logic                    complete;

    // Decode of the address presented in the setup phase.
    always_comb begin
        addr_ext = {1'b0, paddr_i};
        hit_c    = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
        idx_c    = IDX_W'(paddr_i - BASE_OFFSET);
    end

    assign setup     = psel_i && !penable_i;
    assign ready_int = (state == ACCESS) && (cnt == 4'd0);
    assign complete  = ready_int && psel_i && penable_i;

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping psel_i in the access phase is treated as an abort.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel_i || complete) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Read data is captured at setup so it stays stable through the wait
    // cycles and a read right after a write sees the committed value.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            cnt        <= 4'd0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            for (int k = 0; k < SLAVE_REG_N; k++) begin
                regs[k] <= '0;
            end
        end else begin
            wr_pulse_q <= '0;
            if (state == IDLE) begin
                if (setup) begin
                    idx_q    <= idx_c;
                    hit_q    <= hit_c;
                    write_q  <= pwrite_i;
                    wdata_q  <= pwdata_i;
                    strb_q   <= pstrb_i;
                    cnt      <= 4'(WAIT_STATES);
                    prdata_q <= hit_c ? regs[idx_c] : '0;
                end
            end else begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end
                if (!psel_i || complete) begin
                    prdata_q <= '0;
                end
                if (complete && write_q && hit_q) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (strb_q[b]) begin
                            regs[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                    wr_pulse_q[idx_q] <= 1'b1;
                end
            end
        end
    end

    assign pready_o   = ready_int;
    assign pslverr_o  = ready_int && !hit_q;
    assign prdata_o   = prdata_q;
    assign wr_pulse_o = wr_pulse_q;

    for (genvar k = 0; k < SLAVE_REG_N; k++) begin : g_regs_out
        assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb_apb_slave_regs
// Self-checking bench for apb_slave_regs configured with a 16-register window
// at address 32 and two wait states. Each transfer is followed cycle by cycle
// against a transaction-level model of the register bank.
module tb_apb_slave_regs;

    localparam int W    = 2;
    localparam int N    = 16;
    localparam int BASE = 32;

    logic              pclk = 1'b0;
    logic              prst_i;
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [31:0]       paddr_i;
    logic [31:0]       pwdata_i;
    logic [3:0]        pstrb_i;
    logic [31:0]       prdata_o;
    logic              pready_o;
    logic              pslverr_o;
    logic [N*32-1:0]   regs_o;
    logic [N-1:0]      wr_pulse_o;

    apb_slave_regs #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .SLAVE_REG_N (N),
        .BASE_OFFSET (32'(BASE)),
        .WAIT_STATES (W)
    ) dut (
        .pclk_i     (pclk),
        .prst_i     (prst_i),
        .psel_i     (psel_i),
        .penable_i  (penable_i),
        .pwrite_i   (pwrite_i),
        .paddr_i    (paddr_i),
        .pwdata_i   (pwdata_i),
        .pstrb_i    (pstrb_i),
        .prdata_o   (prdata_o),
        .pready_o   (pready_o),
        .pslverr_o  (pslverr_o),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0]  mregs [N];
    logic [31:0]  exp_prdata;
    logic         exp_pready;
    logic         exp_pslverr;
    logic [N-1:0] exp_pulse;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          abort_at;
        int          gap;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic checkOutput(input string where);
        logic [N*32-1:0] flat;
        for (int k = 0; k < N; k++) flat[k*32 +: 32] = mregs[k];
        cmp({where, ".prdata"}, 64'(prdata_o), 64'(exp_prdata));
        cmp({where, ".pready"}, 64'(pready_o), 64'(exp_pready));
        cmp({where, ".pslverr"}, 64'(pslverr_o), 64'(exp_pslverr));
        cmp({where, ".wr_pulse"}, 64'(wr_pulse_o), 64'(exp_pulse));
        total++;
        if (regs_o !== flat) begin
            bad++;
            $display("[TB] FAIL %s.regs got=%h want=%h", where, regs_o, flat);
        end
    endtask

    task automatic applyStimulus(input bit sel, input bit en, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb);
        psel_i    = sel;
        penable_i = en;
        pwrite_i  = wr;
        paddr_i   = addr;
        pwdata_i  = data;
        pstrb_i   = strb;
    endtask

    task automatic setIdleExpect();
        exp_prdata  = '0;
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            checkOutput("idle");
            applyStimulus(0, 0, 0, '0, '0, '0);
            exp_pulse = '0;
        end
    endtask

    // One full APB transfer; abort_at selects a wait cycle in which psel is dropped.
    task automatic doTransfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int abort_at,
                              output logic [31:0] obs_rd, output logic obs_err,
                              output int done_cyc);
        bit          hit;
        int          idx;
        logic [31:0] rd;
        hit      = (addr >= 32'(BASE)) && (addr < 32'(BASE + N));
        idx      = hit ? int'(addr - 32'(BASE)) : 0;
        rd       = hit ? mregs[idx] : 32'h0;
        obs_rd   = '0;
        obs_err  = 1'b0;
        done_cyc = 0;
        @(negedge pclk);
        checkOutput("setup");
        applyStimulus(1, 0, wr, addr, data, strb);
        exp_pulse = '0;
        for (int c = 0; c <= W; c++) begin
            exp_prdata  = rd;
            exp_pready  = (c == W);
            exp_pslverr = (c == W) && !hit;
            @(negedge pclk);
            checkOutput((c == W) ? "complete" : "wait");
            if (c == abort_at) begin
                applyStimulus(0, 0, 0, '0, '0, '0);
                setIdleExpect();
                return;
            end
            if (c == W) begin
                obs_rd   = prdata_o;
                obs_err  = pslverr_o;
                done_cyc = cyc;
            end
            applyStimulus(1, 1, wr, addr, data, strb);
        end
        if (wr && hit) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mregs[idx][b*8 +: 8] = data[b*8 +: 8];
            exp_pulse = N'(1) << idx;
        end
        setIdleExpect();
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          d1;
        int          d2;

        prst_i = 1'b1;
        applyStimulus(0, 0, 0, '0, '0, '0);
        for (int k = 0; k < N; k++) mregs[k] = '0;
        setIdleExpect();
        exp_pulse = '0;

        @(negedge pclk);
        checkOutput("reset1");
        @(negedge pclk);
        checkOutput("reset2");
        prst_i = 1'b0;

        vecs[0]  = '{1, 32'd37, 32'hDEADBEEF, 4'hF, -1, 1, 0, 32'h0, 0};
        vecs[1]  = '{0, 32'd37, 32'h0, 4'h0, -1, 1, 1, 32'hDEADBEEF, 0};
        vecs[2]  = '{1, 32'd34, 32'h11223344, 4'hF, -1, 0, 0, 32'h0, 0};
        vecs[3]  = '{1, 32'd34, 32'hAABBCCDD, 4'b0101, -1, 1, 0, 32'h0, 0};
        vecs[4]  = '{0, 32'd34, 32'h0, 4'h0, -1, 0, 1, 32'h11BB33DD, 0};
        vecs[5]  = '{1, 32'd48, 32'h12345678, 4'hF, -1, 1, 0, 32'h0, 1};
        vecs[6]  = '{0, 32'd48, 32'h0, 4'h0, -1, 1, 1, 32'h0, 1};
        vecs[7]  = '{1, 32'd31, 32'hFFFFFFFF, 4'hF, -1, 1, 0, 32'h0, 1};
        vecs[8]  = '{0, 32'd31, 32'h0, 4'h0, -1, 1, 1, 32'h0, 1};
        vecs[9]  = '{0, 32'd32, 32'h0, 4'h0, -1, 1, 1, 32'h0, 0};
        vecs[10] = '{1, 32'd47, 32'hCAFEF00D, 4'hF, -1, 0, 0, 32'h0, 0};
        vecs[11] = '{1, 32'd47, 32'h00000000, 4'h0, -1, 1, 0, 32'h0, 0};
        vecs[12] = '{0, 32'd47, 32'h0, 4'h0, -1, 1, 1, 32'hCAFEF00D, 0};
        vecs[13] = '{1, 32'd36, 32'hA5A5A5A5, 4'hF, -1, 1, 0, 32'h0, 0};
        vecs[14] = '{1, 32'd36, 32'h12345678, 4'hF, 1, 0, 0, 32'h0, 0};
        vecs[15] = '{0, 32'd36, 32'h0, 4'h0, -1, 1, 1, 32'hA5A5A5A5, 0};
        vecs[16] = '{1, 32'hFFFF_FFF0, 32'h87654321, 4'hF, -1, 1, 0, 32'h0, 1};
        vecs[17] = '{0, 32'h8000_0025, 32'h0, 4'h0, -1, 1, 1, 32'h0, 1};

        foreach (vecs[i]) begin
            doTransfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                       vecs[i].abort_at, rd, err, d1);
            if (vecs[i].abort_at < 0) begin
                cmp($sformatf("vec%0d.err", i), 64'(err), 64'(vecs[i].exp_err));
                if (vecs[i].chk_rd)
                    cmp($sformatf("vec%0d.rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            end
            idleCycles(vecs[i].gap);
        end

        // Back-to-back: read setup lands in the cycle right after the write completes.
        doTransfer(1, 32'd32, 32'h1, 4'hF, -1, rd, err, d1);
        doTransfer(0, 32'd32, 32'h0, 4'h0, -1, rd, err, d2);
        cmp("b2b.rdata", 64'(rd), 64'h1);
        cmp("b2b.spacing", 64'(d2 - d1), 64'(W + 2));
        idleCycles(1);

        // Reset in the second access cycle of a write to register 1.
        @(negedge pclk);
        checkOutput("rst.setup");
        applyStimulus(1, 0, 1, 32'd33, 32'h55, 4'hF);
        exp_pulse  = '0;
        exp_prdata = mregs[1];
        @(negedge pclk);
        checkOutput("rst.acc0");
        applyStimulus(1, 1, 1, 32'd33, 32'h55, 4'hF);
        @(negedge pclk);
        checkOutput("rst.acc1");
        prst_i = 1'b1;
        for (int k = 0; k < N; k++) mregs[k] = '0;
        setIdleExpect();
        @(negedge pclk);
        checkOutput("rst.mid");
        prst_i = 1'b0;
        applyStimulus(0, 0, 0, '0, '0, '0);
        doTransfer(0, 32'd33, 32'h0, 4'h0, -1, rd, err, d1);
        cmp("rst.reg1", 64'(rd), 64'h0);
        doTransfer(0, 32'd37, 32'h0, 4'h0, -1, rd, err, d1);
        cmp("rst.reg5", 64'(rd), 64'h0);
        idleCycles(1);

        // Random traffic around both window edges, with occasional aborts.
        for (int t = 0; t < 150; t++) begin
            int ab;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            doTransfer(1'($urandom_range(0, 1)), 32'(28 + $urandom_range(0, 24)),
                       $urandom, 4'($urandom_range(0, 15)), ab, rd, err, d1);
            idleCycles(int'($urandom_range(0, 2)));
        end
        idleCycles(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
